alu_arbiter: RTL

Two-requester arbiter and sequencer for the shared 32-bit `alu` (operands A/B, 2-bit select, 32-bit result, CarryOut). Each requester presents an operation with a valid/ready handshake. The arbiter grants one requester at a time in round-robin order, registers the operands, runs the ALU for one cycle and holds the tagged result until the consumer accepts it. It also keeps saturating per-requester completion counters for debug.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu.sv | 38 +++
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-requester arbiter/sequencer.
package alu_pkg;

  // Default operand/result width of the datapath.
  localparam int ALU_W_DEFAULT = 32;

  // Width of the ALU operation select.
  localparam int ALU_SEL_W = 2;

  // Operation select encodings understood by the ALU.
  localparam logic [ALU_SEL_W-1:0] SEL_AND = 2'b00;
  localparam logic [ALU_SEL_W-1:0] SEL_OR  = 2'b01;
  localparam logic [ALU_SEL_W-1:0] SEL_ADD = 2'b10;
  localparam logic [ALU_SEL_W-1:0] SEL_SUB = 2'b11;

  // Sequencer states: wait for a request, run the ALU, hold the result.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational W-bit ALU: AND, OR, ADD, SUB with carry out.
// SUB is computed as a + ~b + 1, so CarryOut is high when a >= b (no borrow).
module alu
  import alu_pkg::*;
#(
  parameter int W = ALU_W_DEFAULT
) (
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic [ALU_SEL_W-1:0] sel,
  output logic [W-1:0]         out,
  output logic                 carry_out
);

  logic [W:0] sum_wide;

  // Select the operation; carry is only meaningful for the arithmetic ops.
  always_comb begin
    sum_wide  = '0;
    out       = '0;
    carry_out = 1'b0;
    case (sel)
      SEL_AND: out = a & b;
      SEL_OR:  out = a | b;
      SEL_ADD: begin
        sum_wide  = {1'b0, a} + {1'b0, b};
        out       = sum_wide[W-1:0];
        carry_out = sum_wide[W];
      end
      default: begin
        sum_wide  = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
        out       = sum_wide[W-1:0];
        carry_out = sum_wide[W];
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer sharing one ALU between two requesters.
// One operation in flight at a time: IDLE (grant) -> EXEC (compute) -> RESP (hold).
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W  = ALU_W_DEFAULT,
  parameter int CW = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [W-1:0]         req0_a,
  input  logic [W-1:0]         req0_b,
  input  logic [ALU_SEL_W-1:0] req0_sel,
  input  logic [W-1:0]         req1_a,
  input  logic [W-1:0]         req1_b,
  input  logic [ALU_SEL_W-1:0] req1_sel,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [W-1:0]         rsp_out,
  output logic                 rsp_carry,
  output logic                 rsp_id,
  output logic                 busy,
  output logic [CW-1:0]        done_cnt0,
  output logic [CW-1:0]        done_cnt1
);

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [W-1:0]         a_q, a_d;
  logic [W-1:0]         b_q, b_d;
  logic [ALU_SEL_W-1:0] sel_q, sel_d;
  logic                 id_q, id_d;
  logic [W-1:0]         rsp_out_q, rsp_out_d;
  logic                 rsp_carry_q, rsp_carry_d;
  logic [CW-1:0]        cnt0_q, cnt0_d;
  logic [CW-1:0]        cnt1_q, cnt1_d;
  logic                 grant;
  logic [W-1:0]         alu_out;
  logic                 alu_carry;

  // The ALU only ever sees the latched operands, never the live request inputs.
  alu #(.W(W)) u_alu (
    .a         (a_q),
    .b         (b_q),
    .sel       (sel_q),
    .out       (alu_out),
    .carry_out (alu_carry)
  );

  // Round-robin pick: a lone requester wins; on contention the one not granted last wins.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end else begin
      grant = req_valid[1];
    end
  end

  // Next-state, operand capture, result capture and saturating completion counts.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    b_d          = b_q;
    sel_d        = sel_q;
    id_d         = id_q;
    rsp_out_d    = rsp_out_q;
    rsp_carry_d  = rsp_carry_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    req_ready    = 2'b00;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready    = grant ? 2'b10 : 2'b01;
          a_d          = grant ? req1_a : req0_a;
          b_d          = grant ? req1_b : req0_b;
          sel_d        = grant ? req1_sel : req0_sel;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_out_d   = alu_out;
        rsp_carry_d = alu_carry;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          if (id_q == 1'b0) begin
            if (cnt0_q != '1) cnt0_d = cnt0_q + CW'(1);
          end else begin
            if (cnt1_q != '1) cnt1_d = cnt1_q + CW'(1);
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any in-flight or held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      sel_q        <= '0;
      id_q         <= 1'b0;
      rsp_out_q    <= '0;
      rsp_carry_q  <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      b_q          <= b_d;
      sel_q        <= sel_d;
      id_q         <= id_d;
      rsp_out_q    <= rsp_out_d;
      rsp_carry_q  <= rsp_carry_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_out   = rsp_out_q;
  assign rsp_carry = rsp_carry_q;
  assign rsp_id    = id_q;
  assign done_cnt0 = cnt0_q;
  assign done_cnt1 = cnt1_q;

endmodule
